branch_resolve_queue: RTL and testbench

- Sits directly downstream of the global-history branch predictor.
- Buffers each prediction, in order, until the execute stage resolves that branch.
- On resolution, pops the oldest entry and drives the predictor's training interface (update_en / update_val) for exactly one cycle.
- Flags mispredictions and keeps saturating accuracy counters for the benchmark harness.

---
 rtl/branch_resolve_queue.sv | 183 ++++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order queue between the global-history branch predictor and the
// execute stage. Each issued prediction is buffered until execute resolves
// it; the resolution pops the oldest entry and, one cycle later, emits a
// single-cycle training strobe plus a mispredict flag. Saturating counters
// track resolved branches and mispredictions.
//
// Optional build macro: BRANCH_RESOLVE_QUEUE_FLUSH_EN
//   When defined, a mispredicting resolve discards all younger (wrong-path)
//   entries, including an enqueue in the same cycle.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   pred_val        prediction issued this cycle
//   pred_taken      predicted direction
//   pred_pc         PC of predicted branch
//   pred_rdy        queue not full (combinational from registered occupancy)
//   res_val         execute presents a resolved outcome
//   res_taken       actual direction
//   res_rdy         queue not empty (combinational from registered occupancy)
//   update_en       one-cycle training strobe
//   update_val      actual outcome for training (holds between strobes)
//   update_pc       PC of trained branch (holds between strobes)
//   mispredict      one-cycle strobe with update_en when direction was wrong
//   count           current occupancy
//   num_branches    saturating resolved-branch count
//   num_mispredicts saturating mispredict count
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_val,
    input  logic                     pred_taken,
    input  logic [31:0]              pred_pc,
    output logic                     pred_rdy,
    input  logic                     res_val,
    input  logic                     res_taken,
    output logic                     res_rdy,
    output logic                     update_en,
    output logic                     update_val,
    output logic [31:0]              update_pc,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         num_branches,
    output logic [CNT_W-1:0]         num_mispredicts
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned PC_W  = 32;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t               mem_q [DEPTH];

    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 upd_en_q, upd_en_d;
    logic                 upd_val_q, upd_val_d;
    logic [PC_W-1:0]      upd_pc_q, upd_pc_d;
    logic                 mis_q, mis_d;
    logic [CNT_W-1:0]     nb_q, nb_d;
    logic [CNT_W-1:0]     nm_q, nm_d;

    logic                 full_c;
    logic                 empty_c;
    logic                 enq_fire_c;
    logic                 res_fire_c;
    logic                 pop_mis_c;
    logic                 flush_c;
    logic                 wr_en_c;
    entry_t               head_entry_c;

    // Full/empty decided purely from occupancy
    assign full_c     = (count_q == OCC_W'(DEPTH));
    assign empty_c    = (count_q == OCC_W'(0));
    assign pred_rdy   = !full_c;
    assign res_rdy    = !empty_c;

    assign enq_fire_c   = pred_val && !full_c;
    assign res_fire_c   = res_val && !empty_c;
    assign head_entry_c = mem_q[head_q];
    assign pop_mis_c    = head_entry_c.taken ^ res_taken;

`ifdef BRANCH_RESOLVE_QUEUE_FLUSH_EN
    // Younger entries are wrong-path once the oldest one mispredicts
    assign flush_c = res_fire_c && pop_mis_c;
`else
    assign flush_c = 1'b0;
`endif

    assign wr_en_c = enq_fire_c && !flush_c;

    // Next-state logic for pointers, occupancy, strobes and statistics
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        upd_en_d  = 1'b0;
        upd_val_d = upd_val_q;
        upd_pc_d  = upd_pc_q;
        mis_d     = 1'b0;
        nb_d      = nb_q;
        nm_d      = nm_q;

        if (enq_fire_c) begin
            tail_d = tail_q + PTR_W'(1);
        end

        if (res_fire_c) begin
            head_d    = head_q + PTR_W'(1);
            upd_en_d  = 1'b1;
            upd_val_d = res_taken;
            upd_pc_d  = head_entry_c.pc;
            mis_d     = pop_mis_c;
            if (nb_q != {CNT_W{1'b1}}) begin
                nb_d = nb_q + CNT_W'(1);
            end
            if (pop_mis_c && (nm_q != {CNT_W{1'b1}})) begin
                nm_d = nm_q + CNT_W'(1);
            end
        end

        case ({enq_fire_c, res_fire_c})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase

        if (flush_c) begin
            tail_d  = head_q + PTR_W'(1);
            count_d = OCC_W'(0);
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            upd_en_q  <= 1'b0;
            upd_val_q <= 1'b0;
            upd_pc_q  <= '0;
            mis_q     <= 1'b0;
            nb_q      <= '0;
            nm_q      <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            upd_en_q  <= upd_en_d;
            upd_val_q <= upd_val_d;
            upd_pc_q  <= upd_pc_d;
            mis_q     <= mis_d;
            nb_q      <= nb_d;
            nm_q      <= nm_d;
        end
    end

    // Entry storage, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[tail_q] <= '{taken: pred_taken, pc: pred_pc};
        end
    end

    assign update_en       = upd_en_q;
    assign update_val      = upd_val_q;
    assign update_pc       = upd_pc_q;
    assign mispredict      = mis_q;
    assign count           = count_q;
    assign num_branches    = nb_q;
    assign num_mispredicts = nm_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8, CNT_W=32).
module tb_branch_resolve_queue;

    logic        clk;
    logic        reset;
    logic        pred_val;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        pred_rdy;
    logic        res_val;
    logic        res_taken;
    logic        res_rdy;
    logic        update_en;
    logic        update_val;
    logic [31:0] update_pc;
    logic        mispredict;
    logic [3:0]  count;
    logic [31:0] num_branches;
    logic [31:0] num_mispredicts;

    int n_checks;
    int n_pass;

    branch_resolve_queue #(.DEPTH(8), .CNT_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .pred_val        (pred_val),
        .pred_taken      (pred_taken),
        .pred_pc         (pred_pc),
        .pred_rdy        (pred_rdy),
        .res_val         (res_val),
        .res_taken       (res_taken),
        .res_rdy         (res_rdy),
        .update_en       (update_en),
        .update_val      (update_val),
        .update_pc       (update_pc),
        .mispredict      (mispredict),
        .count           (count),
        .num_branches    (num_branches),
        .num_mispredicts (num_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so registered outputs are visible
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pred_val   = 1'b0;
        pred_taken = 1'b0;
        pred_pc    = 32'h0;
        res_val    = 1'b0;
        res_taken  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        reset = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_pred_rdy", 64'(pred_rdy), 64'd1);
        check("rst_res_rdy", 64'(res_rdy), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_update_en", 64'(update_en), 64'd0);
        check("rst_update_pc", 64'(update_pc), 64'd0);
        check("rst_nb", 64'(num_branches), 64'd0);
        check("rst_nm", 64'(num_mispredicts), 64'd0);
        reset = 1'b1;
        step();

        // Basic: taken@0x100, not-taken@0x104; resolve taken twice
        pred_val = 1'b1; pred_taken = 1'b1; pred_pc = 32'h100;
        step();
        pred_taken = 1'b0; pred_pc = 32'h104;
        step();
        pred_val = 1'b0;
        check("basic_count", 64'(count), 64'd2);
        res_val = 1'b1; res_taken = 1'b1;
        step();
        check("basic1_en", 64'(update_en), 64'd1);
        check("basic1_pc", 64'(update_pc), 64'h100);
        check("basic1_val", 64'(update_val), 64'd1);
        check("basic1_mis", 64'(mispredict), 64'd0);
        step();
        res_val = 1'b0;
        check("basic2_en", 64'(update_en), 64'd1);
        check("basic2_pc", 64'(update_pc), 64'h104);
        check("basic2_mis", 64'(mispredict), 64'd1);
        check("basic2_nb", 64'(num_branches), 64'd2);
        check("basic2_nm", 64'(num_mispredicts), 64'd1);
        step();
        check("basic_idle_en", 64'(update_en), 64'd0);
        check("basic_idle_mis", 64'(mispredict), 64'd0);
        check("basic_hold_pc", 64'(update_pc), 64'h104);
        check("basic_empty_rdy", 64'(res_rdy), 64'd0);

        // Resolve presented while empty is ignored
        res_val = 1'b1; res_taken = 1'b0;
        step();
        res_val = 1'b0;
        check("empty_en", 64'(update_en), 64'd0);
        check("empty_nb", 64'(num_branches), 64'd2);
        check("empty_count", 64'(count), 64'd0);

        // Fill to DEPTH, drop a 9th, then drain in order
        for (int i = 0; i < 8; i++) begin
            pred_val = 1'b1; pred_taken = 1'(i % 2); pred_pc = 32'h200 + 32'(4 * i);
            step();
        end
        check("full_count", 64'(count), 64'd8);
        check("full_pred_rdy", 64'(pred_rdy), 64'd0);
        pred_taken = 1'b1; pred_pc = 32'h999;
        step();
        pred_val = 1'b0;
        check("full_drop_count", 64'(count), 64'd8);
        for (int i = 0; i < 8; i++) begin
            res_val = 1'b1; res_taken = 1'(i % 2);
            step();
            check($sformatf("drain_pc%0d", i), 64'(update_pc), 64'(32'h200 + 32'(4 * i)));
            check($sformatf("drain_mis%0d", i), 64'(mispredict), 64'd0);
        end
        res_val = 1'b1;
        step();
        res_val = 1'b0;
        check("drain_no9_en", 64'(update_en), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        check("drain_nb", 64'(num_branches), 64'd10);
        check("drain_nm", 64'(num_mispredicts), 64'd1);

        // Occupancy 3 with simultaneous enqueue+resolve across pointer wrap
        for (int i = 0; i < 3; i++) begin
            pred_val = 1'b1; pred_taken = 1'b0; pred_pc = 32'h300 + 32'(4 * i);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            pred_val = 1'b1; pred_taken = 1'b0; pred_pc = 32'h30c + 32'(4 * k);
            res_val = 1'b1; res_taken = 1'b0;
            step();
            check($sformatf("sim_count%0d", k), 64'(count), 64'd3);
            check($sformatf("sim_pc%0d", k), 64'(update_pc), 64'(32'h300 + 32'(4 * k)));
        end
        pred_val = 1'b0;
        for (int k = 20; k < 23; k++) begin
            res_val = 1'b1; res_taken = 1'b0;
            step();
            check($sformatf("sim_tail_pc%0d", k), 64'(update_pc), 64'(32'h300 + 32'(4 * k)));
        end
        res_val = 1'b0;
        step();
        check("sim_count_end", 64'(count), 64'd0);
        check("sim_nb", 64'(num_branches), 64'd33);

        // Asynchronous reset mid-stream with a strobe active
        for (int i = 0; i < 5; i++) begin
            pred_val = 1'b1; pred_taken = 1'b0; pred_pc = 32'h600 + 32'(4 * i);
            step();
        end
        pred_val = 1'b0;
        res_val = 1'b1; res_taken = 1'b1;
        step();
        check("pre_rst_en", 64'(update_en), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_en", 64'(update_en), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_nb", 64'(num_branches), 64'd0);
        check("arst_nm", 64'(num_mispredicts), 64'd0);
        check("arst_res_rdy", 64'(res_rdy), 64'd0);
        idle_inputs();
        #1 reset = 1'b1;
        step();
        check("post_rst_en", 64'(update_en), 64'd0);
        check("post_rst_count", 64'(count), 64'd0);
        check("post_rst_res_rdy", 64'(res_rdy), 64'd0);

        // Mispredict with 4 entries plus a simultaneous enqueue
        for (int i = 0; i < 4; i++) begin
            pred_val = 1'b1; pred_taken = 1'b0; pred_pc = 32'h400 + 32'(4 * i);
            step();
        end
        pred_pc = 32'h500; pred_taken = 1'b0;
        res_val = 1'b1; res_taken = 1'b1;
        step();
        pred_val = 1'b0; res_val = 1'b0;
        check("mis_en", 64'(update_en), 64'd1);
        check("mis_pc", 64'(update_pc), 64'h400);
        check("mis_flag", 64'(mispredict), 64'd1);
        check("mis_nm", 64'(num_mispredicts), 64'd1);
`ifdef BRANCH_RESOLVE_QUEUE_FLUSH_EN
        check("flush_count", 64'(count), 64'd0);
        step();
        check("flush_en_off", 64'(update_en), 64'd0);
        check("flush_res_rdy", 64'(res_rdy), 64'd0);
`else
        check("noflush_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            res_val = 1'b1; res_taken = 1'b0;
            step();
            check($sformatf("noflush_pc%0d", i), 64'(update_pc),
                  64'((i < 3) ? (32'h404 + 32'(4 * i)) : 32'h500));
        end
        res_val = 1'b0;
        step();
        check("noflush_count_end", 64'(count), 64'd0);
        check("noflush_nb", 64'(num_branches), 64'd5);
        check("noflush_nm", 64'(num_mispredicts), 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
